// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back, write-allocate data cache with per-set LRU,
// whole-cache flush and saturating hit/miss counters.
module dcache_2way #(
  parameter  int ADDR_W = 8,
  parameter  int SETS   = 4,
  parameter  int WORDS  = 4,
  parameter  int CNT_W  = 16,
  localparam int IDX_W  = $clog2(SETS),
  localparam int OFF_W  = $clog2(WORDS),
  localparam int BLK_W  = 8 * WORDS,
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W,
  localparam int MEM_AW = ADDR_W - OFF_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_cpu_read,
  input  logic              i_cpu_write,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [7:0]        i_cpu_wdata,
  output logic [7:0]        o_cpu_rdata,
  output logic              o_cpu_busywait,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [BLK_W-1:0]  o_mem_wdata,
  input  logic [BLK_W-1:0]  i_mem_rdata,
  input  logic              i_mem_busywait,
  input  logic              i_flush_req,
  output logic              o_flush_done,
  output logic [CNT_W-1:0]  o_hit_cnt,
  output logic [CNT_W-1:0]  o_miss_cnt,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_FLUSH} state_t;

  state_t r_state, w_next;

  logic [1:0]            r_valid [SETS];
  logic [1:0]            r_dirty [SETS];
  logic [TAG_W-1:0]      r_tag   [SETS][2];
  logic [WORDS-1:0][7:0] r_data  [SETS][2];
  logic [SETS-1:0]       r_lru;

  logic             r_victim;
  logic [IDX_W-1:0] r_idx;
  logic [TAG_W-1:0] r_miss_tag;
  logic [IDX_W:0]   r_fl_ptr;
  logic             r_flush_done;
  logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [OFF_W-1:0] w_off;
  logic             w_req, w_hit0, w_hit1, w_hit, w_hit_way;
  logic             w_acc_hit, w_miss, w_victim;
  logic [IDX_W-1:0] w_fl_set;
  logic             w_fl_way, w_fl_dirty, w_fl_step, w_fl_last;

  assign w_tag     = i_cpu_addr[ADDR_W-1 -: TAG_W];
  assign w_idx     = i_cpu_addr[OFF_W +: IDX_W];
  assign w_off     = i_cpu_addr[OFF_W-1:0];
  assign w_req     = i_cpu_read ^ i_cpu_write;
  assign w_hit0    = r_valid[w_idx][0] && (r_tag[w_idx][0] == w_tag);
  assign w_hit1    = r_valid[w_idx][1] && (r_tag[w_idx][1] == w_tag);
  assign w_hit     = w_hit0 || w_hit1;
  assign w_hit_way = w_hit1;
  assign w_acc_hit = (r_state == S_IDLE) && w_req && w_hit;
  assign w_miss    = (r_state == S_IDLE) && w_req && !w_hit;
  assign w_victim  = !r_valid[w_idx][0] ? 1'b0 :
                     !r_valid[w_idx][1] ? 1'b1 : r_lru[w_idx];

  // Flush pointer enumerates (set,way) with way0 first: ptr = {set, way}.
  assign w_fl_set   = r_fl_ptr[IDX_W:1];
  assign w_fl_way   = r_fl_ptr[0];
  assign w_fl_dirty = r_dirty[w_fl_set][w_fl_way];
  assign w_fl_step  = !w_fl_dirty || !i_mem_busywait;
  assign w_fl_last  = &r_fl_ptr;

  assign o_cpu_rdata  = r_data[w_idx][w_hit_way][w_off];
  assign o_flush_done = r_flush_done;
  assign o_hit_cnt    = r_hit_cnt;
  assign o_miss_cnt   = r_miss_cnt;
  assign o_dbg_state  = r_state;

  always_comb begin
    w_next         = r_state;
    o_mem_read     = 1'b0;
    o_mem_write    = 1'b0;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    o_cpu_busywait = w_req && !((r_state == S_IDLE) && w_hit);
    case (r_state)
      S_IDLE: begin
        if (w_miss)
          w_next = r_dirty[w_idx][w_victim] ? S_WRITEBACK : S_REFILL;
        else if (!w_req && i_flush_req)
          w_next = S_FLUSH;
      end
      S_WRITEBACK: begin
        o_mem_write = 1'b1;
        o_mem_addr  = {r_tag[r_idx][r_victim], r_idx};
        o_mem_wdata = r_data[r_idx][r_victim];
        if (!i_mem_busywait) w_next = S_REFILL;
      end
      S_REFILL: begin
        o_mem_read = 1'b1;
        o_mem_addr = {r_miss_tag, r_idx};
        if (!i_mem_busywait) w_next = S_IDLE;
      end
      S_FLUSH: begin
        if (w_fl_dirty) begin
          o_mem_write = 1'b1;
          o_mem_addr  = {r_tag[w_fl_set][w_fl_way], w_fl_set};
          o_mem_wdata = r_data[w_fl_set][w_fl_way];
        end
        if (w_fl_step && w_fl_last) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lru        <= '0;
      r_fl_ptr     <= '0;
      r_flush_done <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_victim     <= 1'b0;
      r_idx        <= '0;
      r_miss_tag   <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
      end
    end else begin
      r_state      <= w_next;
      r_flush_done <= (r_state == S_FLUSH) && w_fl_step && w_fl_last;
      if (w_acc_hit) begin
        r_lru[w_idx] <= ~w_hit_way;
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
        if (i_cpu_write) begin
          r_data[w_idx][w_hit_way][w_off] <= i_cpu_wdata;
          r_dirty[w_idx][w_hit_way]       <= 1'b1;
        end
      end
      // Miss context is latched so a withdrawn request still completes its refill.
      if (w_miss) begin
        r_victim   <= w_victim;
        r_idx      <= w_idx;
        r_miss_tag <= w_tag;
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
      end
      if ((r_state == S_REFILL) && !i_mem_busywait) begin
        r_data[r_idx][r_victim]  <= i_mem_rdata;
        r_tag[r_idx][r_victim]   <= r_miss_tag;
        r_valid[r_idx][r_victim] <= 1'b1;
        r_dirty[r_idx][r_victim] <= 1'b0;
      end
      if ((r_state == S_FLUSH) && w_fl_step) begin
        r_dirty[w_fl_set][w_fl_way] <= 1'b0;
        r_fl_ptr                    <= r_fl_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way: table of CPU operations with a cycle-level
// memory responder, plus hand-written flush and mid-refill reset sequences.
module tb_dcache_2way;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        chk_rd;
    logic [7:0]  exp_rdata;
    logic        exp_wb;
    logic [5:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exp_rf;
    logic [5:0]  rf_addr;
    logic [31:0] rf_data;
    int          exp_hit;
    int          exp_miss;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_cpu_read, i_cpu_write;
  logic [7:0]  i_cpu_addr, i_cpu_wdata;
  logic [7:0]  o_cpu_rdata;
  logic        o_cpu_busywait, o_mem_read, o_mem_write;
  logic [5:0]  o_mem_addr;
  logic [31:0] o_mem_wdata, i_mem_rdata;
  logic        i_mem_busywait, i_flush_req, o_flush_done;
  logic [15:0] o_hit_cnt, o_miss_cnt;
  logic [1:0]  o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  dcache_2way dut (
    .clock(clock), .reset(reset),
    .i_cpu_read(i_cpu_read), .i_cpu_write(i_cpu_write),
    .i_cpu_addr(i_cpu_addr), .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_rdata(o_cpu_rdata), .o_cpu_busywait(o_cpu_busywait),
    .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .i_mem_busywait(i_mem_busywait),
    .i_flush_req(i_flush_req), .o_flush_done(o_flush_done),
    .o_hit_cnt(o_hit_cnt), .o_miss_cnt(o_miss_cnt),
    .o_dbg_state(o_dbg_state)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wdata, input logic chk_rd,
                              input logic [7:0] exp_rdata, input logic exp_wb,
                              input logic [5:0] wb_addr, input logic [31:0] wb_data,
                              input logic exp_rf, input logic [5:0] rf_addr,
                              input logic [31:0] rf_data, input int exp_hit,
                              input int exp_miss);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.chk_rd = chk_rd; v.exp_rdata = exp_rdata;
    v.exp_wb = exp_wb; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.exp_rf = exp_rf; v.rf_addr = rf_addr; v.rf_data = rf_data;
    v.exp_hit = exp_hit; v.exp_miss = exp_miss;
    return v;
  endfunction

  // Entered and left at negedge+1; memory answers after 3 busy cycles.
  task automatic run_op(input vec_t v);
    int          bcnt = 0;
    bit          done = 0, seen_wb = 0, seen_rf = 0, both = 0;
    logic [5:0]  wa = '0, ra = '0;
    logic [31:0] wd = '0;
    i_cpu_read  = v.rd;
    i_cpu_write = v.wr;
    i_cpu_addr  = v.addr;
    i_cpu_wdata = v.wdata;
    i_mem_rdata = v.rf_data;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (o_mem_read && o_mem_write) both = 1;
      if (!o_cpu_busywait) begin
        done = 1;
        if (v.chk_rd) check($sformatf("rdata@%0h", v.addr), 32'(o_cpu_rdata), 32'(v.exp_rdata));
      end else begin
        if (o_mem_write && !seen_wb) begin seen_wb = 1; wa = o_mem_addr; wd = o_mem_wdata; end
        if (o_mem_read && !seen_rf) begin seen_rf = 1; ra = o_mem_addr; end
        if (o_mem_read || o_mem_write) begin
          if (bcnt < 3) begin i_mem_busywait = 1'b1; bcnt++; end
          else begin i_mem_busywait = 1'b0; bcnt = 0; end
        end else begin
          i_mem_busywait = 1'b0;
        end
      end
      @(negedge clock);
    end
    check($sformatf("done@%0h", v.addr), 32'(done), 32'd1);
    check($sformatf("mem_excl@%0h", v.addr), 32'(both), 32'd0);
    check($sformatf("wb_seen@%0h", v.addr), 32'(seen_wb), 32'(v.exp_wb));
    if (v.exp_wb) begin
      check($sformatf("wb_addr@%0h", v.addr), 32'(wa), 32'(v.wb_addr));
      check($sformatf("wb_data@%0h", v.addr), wd, v.wb_data);
    end
    check($sformatf("rf_seen@%0h", v.addr), 32'(seen_rf), 32'(v.exp_rf));
    if (v.exp_rf) check($sformatf("rf_addr@%0h", v.addr), 32'(ra), 32'(v.rf_addr));
    i_cpu_read  = 1'b0;
    i_cpu_write = 1'b0;
    #1;
    check($sformatf("hit_cnt@%0h", v.addr), 32'(o_hit_cnt), 32'(v.exp_hit));
    check($sformatf("miss_cnt@%0h", v.addr), 32'(o_miss_cnt), 32'(v.exp_miss));
  endtask

  task automatic run_flush(input int exp_n, input logic [5:0] a0, input logic [31:0] d0,
                           input logic [5:0] a1, input logic [31:0] d1, input int exp_edges);
    logic [5:0]  wb_a[$];
    logic [31:0] wb_d[$];
    logic [5:0]  ea[2];
    logic [31:0] ed[2];
    int          bcnt = 0, edges = 0;
    bit          fin = 0, in_xfer = 0, both = 0;
    ea[0] = a0; ea[1] = a1; ed[0] = d0; ed[1] = d1;
    i_flush_req = 1'b1;
    @(posedge clock);
    #1 i_flush_req = 1'b0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clock);
      #1;
      if (o_mem_read && o_mem_write) both = 1;
      if (o_flush_done) begin
        fin = 1;
      end else begin
        if (edges == 0) begin
          i_cpu_read = 1'b1; i_cpu_addr = 8'h40;
          #1 check("flush_busywait", 32'(o_cpu_busywait), 32'd1);
          i_cpu_read = 1'b0;
        end
        if (o_mem_write) begin
          if (!in_xfer) begin wb_a.push_back(o_mem_addr); wb_d.push_back(o_mem_wdata); in_xfer = 1; end
          if (bcnt < 3) begin i_mem_busywait = 1'b1; bcnt++; end
          else begin i_mem_busywait = 1'b0; bcnt = 0; in_xfer = 0; end
        end else begin
          i_mem_busywait = 1'b0;
        end
        @(posedge clock);
        edges++;
      end
    end
    check("flush_done_seen", 32'(fin), 32'd1);
    check("flush_edges", 32'(edges), 32'(exp_edges));
    check("flush_mem_excl", 32'(both), 32'd0);
    check("flush_wb_count", 32'(wb_a.size()), 32'(exp_n));
    for (int i = 0; i < exp_n && i < wb_a.size(); i++) begin
      check($sformatf("flush_wb_addr%0d", i), 32'(wb_a[i]), 32'(ea[i]));
      check($sformatf("flush_wb_data%0d", i), wb_d[i], ed[i]);
    end
    @(negedge clock);
    #1 check("flush_done_pulse", 32'(o_flush_done), 32'd0);
    check("flush_back_idle", 32'(o_dbg_state), 32'd0);
  endtask

  vec_t vecs[13];
  bit   seen;

  initial begin
    vecs[0]  = mk(1, 0, 8'h15, 8'h00, 1, 8'hBB, 0, 6'h00, 32'h0, 1, 6'h05, 32'hDDCCBBAA, 1, 1);
    vecs[1]  = mk(0, 1, 8'h17, 8'h5A, 0, 8'h00, 0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 2, 1);
    vecs[2]  = mk(1, 0, 8'h17, 8'h00, 1, 8'h5A, 0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 3, 1);
    vecs[3]  = mk(1, 0, 8'h35, 8'h00, 1, 8'h22, 0, 6'h00, 32'h0, 1, 6'h0D, 32'h44332211, 4, 2);
    vecs[4]  = mk(1, 0, 8'h15, 8'h00, 1, 8'hBB, 0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 5, 2);
    vecs[5]  = mk(1, 0, 8'h55, 8'h00, 1, 8'h66, 0, 6'h00, 32'h0, 1, 6'h15, 32'h88776655, 6, 3);
    vecs[6]  = mk(1, 0, 8'h75, 8'h00, 1, 8'hAA, 1, 6'h05, 32'h5ACCBBAA, 1, 6'h1D, 32'hCCBBAA99, 7, 4);
    vecs[7]  = mk(1, 0, 8'h00, 8'h00, 1, 8'h00, 0, 6'h00, 32'h0, 1, 6'h00, 32'h03020100, 8, 5);
    vecs[8]  = mk(0, 1, 8'h40, 8'hEE, 0, 8'h00, 0, 6'h00, 32'h0, 1, 6'h10, 32'h13121110, 9, 6);
    vecs[9]  = mk(0, 1, 8'h08, 8'h77, 0, 8'h00, 0, 6'h00, 32'h0, 1, 6'h02, 32'h23222120, 10, 7);
    vecs[10] = mk(1, 0, 8'h40, 8'h00, 1, 8'hEE, 0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 11, 7);
    vecs[11] = mk(1, 0, 8'h0B, 8'h00, 1, 8'h23, 0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 12, 7);
    vecs[12] = mk(1, 1, 8'h15, 8'h00, 0, 8'h00, 0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 12, 7);

    reset = 1'b1;
    i_cpu_read = 1'b0; i_cpu_write = 1'b0; i_cpu_addr = '0; i_cpu_wdata = '0;
    i_mem_rdata = '0; i_mem_busywait = 1'b0; i_flush_req = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_busywait", 32'(o_cpu_busywait), 32'd0);
    check("rst_mem_read", 32'(o_mem_read), 32'd0);
    check("rst_mem_write", 32'(o_mem_write), 32'd0);
    check("rst_flush_done", 32'(o_flush_done), 32'd0);
    check("rst_hit_cnt", 32'(o_hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(o_miss_cnt), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'd0);

    for (int i = 0; i < 13; i++) run_op(vecs[i]);

    // Dirty lines: set0 way1 (tag4) and set2 way0 (tag0); 1+4+1+1+4+1+1+1 cycles.
    run_flush(2, 6'h10, 32'h131211EE, 6'h02, 32'h23222177, 14);
    run_flush(0, 6'h00, 32'h0, 6'h00, 32'h0, 8);
    run_op(mk(1, 0, 8'h40, 8'h00, 1, 8'hEE, 0, 6'h00, 32'h0, 0, 6'h00, 32'h0, 13, 7));

    // Reset while the refill is outstanding.
    i_mem_busywait = 1'b1;
    i_cpu_read = 1'b1; i_cpu_addr = 8'h95;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (o_mem_read) seen = 1;
      else @(negedge clock);
    end
    check("rst_mid_refill_started", 32'(seen), 32'd1);
    reset = 1'b1;
    i_cpu_read = 1'b0;
    @(posedge clock);
    #1;
    check("rst_mid_mem_read", 32'(o_mem_read), 32'd0);
    check("rst_mid_state", 32'(o_dbg_state), 32'd0);
    check("rst_mid_hit_cnt", 32'(o_hit_cnt), 32'd0);
    check("rst_mid_miss_cnt", 32'(o_miss_cnt), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    i_mem_busywait = 1'b0;
    #1;
    run_op(mk(1, 0, 8'h95, 8'h00, 1, 8'h5B, 0, 6'h00, 32'h0, 1, 6'h25, 32'h5D5C5B5A, 1, 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
